conv3x3_pipe: RTL and testbench

CONV3X3_PIPE -- requirements
Module: conv3x3_pipe

---
 rtl/conv3x3_pipe.sv | 179 +++++++++++++++++
 tb/tb_conv3x3_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_pipe.sv
// 3x3 signed convolution with shadow/active coefficient banks; optional ReLU via CONV3X3_RELU_EN.
// Latency: 3 cycles (products, row sums, total+bias); one window per cycle.
// Backpressure: none; DIN_VALID=0 inserts bubbles and DOUT holds its last value.
module conv3x3_pipe #(
    parameter int DW = 16,
    parameter int WW = 16,
    localparam int AW = DW + WW + 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 DIN_VALID,
    input  logic                 LAST_IN_LINE,
    input  logic                 LAST_PIXEL,
    input  logic signed [DW-1:0] X_11,
    input  logic signed [DW-1:0] X_12,
    input  logic signed [DW-1:0] X_13,
    input  logic signed [DW-1:0] X_21,
    input  logic signed [DW-1:0] X_22,
    input  logic signed [DW-1:0] X_23,
    input  logic signed [DW-1:0] X_31,
    input  logic signed [DW-1:0] X_32,
    input  logic signed [DW-1:0] X_33,
    input  logic                 W_WE,
    input  logic [3:0]           W_ADDR,
    input  logic signed [WW-1:0] W_DATA,
    input  logic                 W_COMMIT,
    output logic                 COMMIT_PENDING,
    output logic                 BUSY,
    output logic                 DOUT_VALID,
    output logic signed [AW-1:0] DOUT,
    output logic                 DOUT_LAST_IN_LINE,
    output logic                 DOUT_LAST_PIXEL
);
    localparam int PW = DW + WW;      // single product width
    localparam int RW = PW + 2;       // row sum of three products

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_pending, w_pending_nxt, w_apply;
    logic signed [WW-1:0]  r_shadow [10];
    logic signed [WW-1:0]  r_active [10];
    logic signed [DW-1:0]  w_x [9];

    logic                  r_v1, r_v2, r_v3;
    logic                  r_lil1, r_lil2, r_lil3;
    logic                  r_lp1, r_lp2, r_lp3;
    logic signed [PW-1:0]  r_prod [9];
    logic signed [WW-1:0]  r_bias1, r_bias2;
    logic signed [RW-1:0]  r_row [3];
    logic signed [AW-1:0]  r_dout, w_sum, w_res;

    assign w_x[0] = X_11;
    assign w_x[1] = X_12;
    assign w_x[2] = X_13;
    assign w_x[3] = X_21;
    assign w_x[4] = X_22;
    assign w_x[5] = X_23;
    assign w_x[6] = X_31;
    assign w_x[7] = X_32;
    assign w_x[8] = X_33;

    // Frame tracking and commit decision: a commit applies immediately when idle,
    // otherwise it waits for the edge that accepts the frame's last pixel.
    always_comb begin
        w_state_nxt   = r_state;
        w_apply       = 1'b0;
        w_pending_nxt = r_pending;
        case (r_state)
            S_IDLE: begin
                if (W_COMMIT) w_apply = 1'b1;
                if (DIN_VALID && !LAST_PIXEL) w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                if (DIN_VALID && LAST_PIXEL) begin
                    w_state_nxt = S_IDLE;
                    w_apply     = r_pending | W_COMMIT;
                end else if (W_COMMIT) begin
                    w_pending_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_apply) w_pending_nxt = 1'b0;
    end

    // FSM state and pending-commit flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    // Coefficient banks: the copy takes the shadow as held before this edge, so a
    // coincident write lands in the shadow only.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 10; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            if (W_WE && (W_ADDR <= 4'd9)) r_shadow[W_ADDR] <= W_DATA;
            if (w_apply) r_active <= r_shadow;
        end
    end

    // S1: nine products plus the bias that belongs to this window's coefficient set.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_v1    <= 1'b0;
            r_lil1  <= 1'b0;
            r_lp1   <= 1'b0;
            r_bias1 <= '0;
            for (int i = 0; i < 9; i++) r_prod[i] <= '0;
        end else begin
            r_v1    <= DIN_VALID;
            r_lil1  <= DIN_VALID & LAST_IN_LINE;
            r_lp1   <= DIN_VALID & LAST_PIXEL;
            r_bias1 <= r_active[9];
            for (int i = 0; i < 9; i++) r_prod[i] <= PW'(w_x[i]) * PW'(r_active[i]);
        end
    end

    // S2: per-row sums.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_v2    <= 1'b0;
            r_lil2  <= 1'b0;
            r_lp2   <= 1'b0;
            r_bias2 <= '0;
            for (int r = 0; r < 3; r++) r_row[r] <= '0;
        end else begin
            r_v2    <= r_v1;
            r_lil2  <= r_lil1;
            r_lp2   <= r_lp1;
            r_bias2 <= r_bias1;
            for (int r = 0; r < 3; r++)
                r_row[r] <= RW'(r_prod[3*r]) + RW'(r_prod[3*r+1]) + RW'(r_prod[3*r+2]);
        end
    end

    // S3 combinational total; optional clamp of negatives to zero.
    always_comb begin
        w_sum = AW'(r_row[0]) + AW'(r_row[1]) + AW'(r_row[2]) + AW'(r_bias2);
`ifdef CONV3X3_RELU_EN
        w_res = w_sum[AW-1] ? '0 : w_sum;
`else
        w_res = w_sum;
`endif
    end

    // S3 output register; data only updates on a valid result so bubbles hold DOUT.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_v3   <= 1'b0;
            r_lil3 <= 1'b0;
            r_lp3  <= 1'b0;
            r_dout <= '0;
        end else begin
            r_v3   <= r_v2;
            r_lil3 <= r_lil2;
            r_lp3  <= r_lp2;
            if (r_v2) r_dout <= w_res;
        end
    end

    assign DOUT              = r_dout;
    assign DOUT_VALID        = r_v3;
    assign DOUT_LAST_IN_LINE = r_lil3;
    assign DOUT_LAST_PIXEL   = r_lp3;
    assign BUSY              = (r_state == S_BUSY);
    assign COMMIT_PENDING    = r_pending;

endmodule

// File: tb/tb_conv3x3_pipe.sv
// Randomized scoreboard bench for conv3x3_pipe with a coefficient-bank reference model.
// Expected results are queued at issue time and popped by an independent output monitor.
// The DUT has no backpressure; the bench only inserts random input gaps.
module tb_conv3x3_pipe;
    localparam int DW = 16;
    localparam int WW = 16;
    localparam int AW = DW + WW + 4;

    typedef struct {
        longint d;
        bit     lil;
        bit     lp;
        int     cyc;
    } exp_t;

    logic                 CLK = 1'b0;
    logic                 RST, DIN_VALID, LAST_IN_LINE, LAST_PIXEL;
    logic                 W_WE, W_COMMIT;
    logic [3:0]           W_ADDR;
    logic signed [WW-1:0] W_DATA;
    logic signed [DW-1:0] tx [9];
    logic                 COMMIT_PENDING, BUSY, DOUT_VALID;
    logic signed [AW-1:0] DOUT;
    logic                 DOUT_LAST_IN_LINE, DOUT_LAST_PIXEL;

    exp_t q [$];
    int   total = 0, bad = 0, cyc = 0;
    int   n_v = 0, n_lil = 0, n_lp = 0, lp_at = 0;
    bit   done = 0;

    // reference model state
    logic signed [WW-1:0] m_sh [10];
    logic signed [WW-1:0] m_act [10];
    bit   m_busy = 0, m_pend = 0;

    conv3x3_pipe #(.DW(DW), .WW(WW)) dut (
        .CLK(CLK), .RST(RST), .DIN_VALID(DIN_VALID),
        .LAST_IN_LINE(LAST_IN_LINE), .LAST_PIXEL(LAST_PIXEL),
        .X_11(tx[0]), .X_12(tx[1]), .X_13(tx[2]),
        .X_21(tx[3]), .X_22(tx[4]), .X_23(tx[5]),
        .X_31(tx[6]), .X_32(tx[7]), .X_33(tx[8]),
        .W_WE(W_WE), .W_ADDR(W_ADDR), .W_DATA(W_DATA), .W_COMMIT(W_COMMIT),
        .COMMIT_PENDING(COMMIT_PENDING), .BUSY(BUSY), .DOUT_VALID(DOUT_VALID),
        .DOUT(DOUT), .DOUT_LAST_IN_LINE(DOUT_LAST_IN_LINE), .DOUT_LAST_PIXEL(DOUT_LAST_PIXEL)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Output monitor: every result must match the head of the scoreboard at its due cycle.
    always @(negedge CLK) begin
        if (!done) begin
            if (DOUT_VALID) begin
                n_v++;
                if (DOUT_LAST_IN_LINE) n_lil++;
                if (DOUT_LAST_PIXEL) begin
                    n_lp++;
                    lp_at = n_v;
                end
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out got=%0d at cyc=%0d", longint'(DOUT), cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (longint'(DOUT) != e.d || DOUT_LAST_IN_LINE != e.lil ||
                        DOUT_LAST_PIXEL != e.lp || cyc != e.cyc) begin
                        bad++;
                        $display("FAIL out got d=%0d lil=%0b lp=%0b cyc=%0d exp d=%0d lil=%0b lp=%0b cyc=%0d",
                                 longint'(DOUT), DOUT_LAST_IN_LINE, DOUT_LAST_PIXEL, cyc,
                                 e.d, e.lil, e.lp, e.cyc);
                    end
                end
            end else begin
                if (DOUT_LAST_IN_LINE || DOUT_LAST_PIXEL) begin
                    total++;
                    bad++;
                    $display("FAIL sideband_without_valid lil=%0b lp=%0b exp 0", DOUT_LAST_IN_LINE, DOUT_LAST_PIXEL);
                end
                if (q.size() > 0 && q[0].cyc <= cyc) begin
                    exp_t e;
                    e = q.pop_front();
                    total++;
                    bad++;
                    $display("FAIL missing_out got valid=0 exp d=%0d at cyc=%0d", e.d, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string nm, input longint got, input longint expv);
        total++;
        if (got != expv) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, expv);
        end
    endtask

    // One clock of stimulus; the model predicts the result and updates coefficient state.
    task automatic drive(input bit v, input bit lil, input bit lp, input bit we,
                         input logic [3:0] a, input logic signed [WW-1:0] d,
                         input bit cm, input bit rst);
        exp_t   e;
        longint acc;
        bit     apply;
        RST = rst; DIN_VALID = v; LAST_IN_LINE = lil; LAST_PIXEL = lp;
        W_WE = we; W_ADDR = a; W_DATA = d; W_COMMIT = cm;
        if (rst) begin
            // results due before the reset edge still emerge; later ones are lost
            while (q.size() > 0 && q[q.size()-1].cyc > cyc) void'(q.pop_back());
            for (int i = 0; i < 10; i++) begin
                m_sh[i]  = '0;
                m_act[i] = '0;
            end
            m_busy = 0;
            m_pend = 0;
        end else begin
            if (v) begin
                acc = longint'(m_act[9]);
                for (int i = 0; i < 9; i++) acc += longint'(tx[i]) * longint'(m_act[i]);
`ifdef CONV3X3_RELU_EN
                if (acc < 0) acc = 0;
`endif
                e.d = acc; e.lil = lil; e.lp = lp; e.cyc = cyc + 3;
                q.push_back(e);
            end
            apply = (cm && !m_busy) || (m_busy && v && lp && (m_pend || cm));
            if (apply) m_act = m_sh;
            if (we && a <= 4'd9) m_sh[a] = d;
            if (apply) m_pend = 0;
            else if (cm && m_busy) m_pend = 1;
            if (v) m_busy = !lp;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 4'd0, '0, 0, 0);
    endtask

    task automatic wr(input logic [3:0] a, input logic signed [WW-1:0] d);
        drive(0, 0, 0, 1, a, d, 0, 0);
    endtask

    task automatic commit();
        drive(0, 0, 0, 0, 4'd0, '0, 1, 0);
    endtask

    task automatic win(input bit lil, input bit lp);
        drive(1, lil, lp, 0, 4'd0, '0, 0, 0);
    endtask

    task automatic rand_x();
        for (int i = 0; i < 9; i++) tx[i] = DW'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) idle();
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 9; i++) tx[i] = '0;
        for (int i = 0; i < 10; i++) begin
            m_sh[i]  = '0;
            m_act[i] = '0;
        end
        drive(0, 0, 0, 0, 4'd0, '0, 0, 1);
        drive(1, 1, 1, 1, 4'd4, 16'sd3, 1, 1);   // inputs ignored under reset
        chk("rst_dout_valid", DOUT_VALID, 0);
        chk("rst_dout", longint'(DOUT), 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_pending", COMMIT_PENDING, 0);
        chk("rst_sideband", {DOUT_LAST_IN_LINE, DOUT_LAST_PIXEL}, 0);
        rand_x();
        win(0, 1);                                 // zero weights after reset
        drain();

        // identity kernel
        for (int a = 0; a < 10; a++) wr(4'(a), (a == 4) ? 16'sd1 : 16'sd0);
        commit();
        rand_x();
        tx[4] = 16'sd5;
        win(0, 1);
        drain();

        // all-ones kernel with negative bias over 1..9
        for (int a = 0; a < 9; a++) wr(4'(a), 16'sd1);
        wr(4'd9, -16'sd50);
        commit();
        for (int i = 0; i < 9; i++) tx[i] = DW'(i + 1);
        win(0, 1);
        drain();

        // deferred commit across a frame
        for (int a = 0; a < 10; a++) wr(4'(a), (a == 4) ? 16'sd1 : 16'sd0);
        commit();
        rand_x();
        win(0, 0);
        chk("frame_busy", BUSY, 1);
        rand_x();
        win(0, 0);
        wr(4'd4, 16'sd2);
        rand_x();
        drive(1, 0, 0, 0, 4'd0, '0, 1, 0);         // commit alongside a window
        chk("deferred_pending", COMMIT_PENDING, 1);
        chk("deferred_busy", BUSY, 1);
        rand_x();
        drive(1, 1, 0, 0, 4'd0, '0, 1, 0);         // repeated commit is harmless
        chk("deferred_pending_again", COMMIT_PENDING, 1);
        rand_x();
        drive(1, 1, 1, 1, 4'd4, 16'sd7, 0, 0);     // shadow write on the applying edge
        chk("applied_pending", COMMIT_PENDING, 0);
        chk("applied_busy", BUSY, 0);
        for (int i = 0; i < 9; i++) tx[i] = '0;
        tx[4] = 16'sd5;
        win(0, 1);                                 // expects 10: weight 2, not 7
        drain();

        // 32x24 streaming frame with random gaps, stray writes and a mid-frame commit
        n_v = 0; n_lil = 0; n_lp = 0; lp_at = 0;
        for (int a = 0; a < 10; a++) wr(4'(a), WW'($urandom));
        commit();
        for (int r = 0; r < 24; r++) begin
            for (int c = 0; c < 32; c++) begin
                while ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 1) == 1) wr(4'($urandom_range(0, 15)), WW'($urandom));
                    else idle();
                end
                rand_x();
                drive(1, c == 31, (r == 23) && (c == 31), 0, 4'd0, '0,
                      (r == 12) && (c == 0), 0);
                if (r == 12 && c == 0) chk("stream_pending", COMMIT_PENDING, 1);
            end
        end
        drain();
        chk("stream_valid_count", n_v, 768);
        chk("stream_lil_count", n_lil, 24);
        chk("stream_lp_count", n_lp, 1);
        chk("stream_lp_position", lp_at, 768);

        // reset with windows in flight
        for (int a = 0; a < 10; a++) wr(4'(a), WW'($urandom));
        commit();
        for (int k = 0; k < 3; k++) begin
            rand_x();
            win(0, 0);
        end
        drive(0, 0, 0, 0, 4'd0, '0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            chk("post_rst_valid", DOUT_VALID, 0);
            idle();
        end
        chk("post_rst_busy", BUSY, 0);
        chk("post_rst_pending", COMMIT_PENDING, 0);
        rand_x();
        win(0, 1);                                 // active bank cleared: expects 0
        drain();

        done = 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
